// File: rtl/sm_path_pkg.sv
// Shared definitions for the path sequencer: move codes, state encoding,
// stop-node code and the packed path-entry record.
package sm_path_pkg;

    localparam logic [1:0] MV_STRAIGHT = 2'b00;
    localparam logic [1:0] MV_LEFT     = 2'b01;
    localparam logic [1:0] MV_RIGHT    = 2'b10;
    localparam logic [1:0] MV_REVERSE  = 2'b11;

    localparam logic [5:0] STOP_NODE = 6'd22;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

    // Bit layout matches the write-data byte: [7:6] move, [5:0] node.
    typedef struct packed {
        logic [1:0] move;
        logic [5:0] node;
    } entry_t;

    // Returns {reverse, right, left}; straight leaves all three low.
    function automatic logic [2:0] move_to_turn(input logic [1:0] mv);
        case (mv)
            MV_LEFT:    return 3'b001;
            MV_RIGHT:   return 3'b010;
            MV_REVERSE: return 3'b100;
            default:    return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/path_sequencer_if.sv
// Bus bundle between the path sequencer and its host / line-follower:
// path-memory writes, start request, node events and sequencer outputs.
interface path_sequencer_if;

    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [4:0] path_len;
    logic       start;
    logic       node_event;

    logic [5:0] node;
    logic       left;
    logic       right;
    logic       reverse;
    logic [3:0] step;
    logic       busy;
    logic       done;
    logic       fault;

    modport master (
        output wr_en, wr_addr, wr_data, path_len, start, node_event,
        input  node, left, right, reverse, step, busy, done, fault
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, path_len, start, node_event,
        output node, left, right, reverse, step, busy, done, fault
    );

endinterface

// File: rtl/path_mem.sv
// Path entry register file: synchronous write, asynchronous read so the
// current entry is visible in the same cycle the step index changes.
module path_mem
    import sm_path_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  entry_t        wdata_i,
    input  logic [AW-1:0] raddr_i,
    output entry_t        rdata_o
);

    entry_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/path_sequencer.sv
// Path sequencer: steps through a stored list of nodes/turns on rising node
// events. Optional watchdog compiled in with PATH_SEQUENCER_WATCHDOG_EN.
module path_sequencer #(
    parameter int         DEPTH     = 16,
    parameter int         TIMEOUT   = 50_000_000,
    parameter logic [5:0] STOP_NODE = sm_path_pkg::STOP_NODE
) (
    input logic             clk_50,
    input logic             reset,
    path_sequencer_if.slave bus
);

    import sm_path_pkg::*;

    if (TIMEOUT < 2) begin : g_timeout_chk
        $error("path_sequencer: TIMEOUT must be at least 2");
    end

    state_e     state_q, state_d;
    logic [3:0] step_q, step_d;
    logic [4:0] len_q, len_d;
    logic       evt_q;
    logic       evt_rise;
    logic       start_ok;
    logic       last_step;
    logic       mem_we;
    entry_t     rd_entry;
    logic [2:0] turn;

`ifdef PATH_SEQUENCER_WATCHDOG_EN
    logic [31:0] wd_q, wd_d;
`endif

    // Only a low-to-high transition of the level input counts as an arrival.
    assign evt_rise = bus.node_event & ~evt_q;

    assign start_ok = bus.start
                   && (state_q == ST_IDLE || state_q == ST_DONE)
                   && (bus.path_len != 5'd0)
                   && (int'(bus.path_len) <= DEPTH);

    assign last_step = ({1'b0, step_q} == (len_q - 5'd1));

    // A write coinciding with an accepted start is dropped so the path
    // being launched cannot change under it.
    assign mem_we = bus.wr_en && !reset && (state_q != ST_RUN) && !start_ok;

    path_mem #(
        .DEPTH (DEPTH),
        .AW    (4)
    ) u_path_mem (
        .clk_i   (clk_50),
        .we_i    (mem_we),
        .waddr_i (bus.wr_addr),
        .wdata_i (entry_t'(bus.wr_data)),
        .raddr_i (step_q),
        .rdata_o (rd_entry)
    );

    always_ff @(posedge clk_50) begin
        if (reset) begin
            state_q <= ST_IDLE;
            step_q  <= 4'd0;
            len_q   <= 5'd0;
            evt_q   <= 1'b0;
`ifdef PATH_SEQUENCER_WATCHDOG_EN
            wd_q    <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            len_q   <= len_d;
            evt_q   <= bus.node_event;
`ifdef PATH_SEQUENCER_WATCHDOG_EN
            wd_q    <= wd_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        len_d   = len_q;
`ifdef PATH_SEQUENCER_WATCHDOG_EN
        wd_d    = wd_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_d = ST_RUN;
                    step_d  = 4'd0;
                    len_d   = bus.path_len;
`ifdef PATH_SEQUENCER_WATCHDOG_EN
                    wd_d    = 32'd0;
`endif
                end
            end
            ST_RUN: begin
                // An event in the timeout cycle takes priority over the fault.
                if (evt_rise) begin
`ifdef PATH_SEQUENCER_WATCHDOG_EN
                    wd_d = 32'd0;
`endif
                    if (last_step) begin
                        state_d = ST_DONE;
                    end else begin
                        step_d = step_q + 4'd1;
                    end
                end else begin
`ifdef PATH_SEQUENCER_WATCHDOG_EN
                    if (wd_q == 32'(TIMEOUT - 1)) begin
                        state_d = ST_FAULT;
                    end else begin
                        wd_d = wd_q + 32'd1;
                    end
`endif
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_comb begin
        turn     = move_to_turn(rd_entry.move);
        bus.node    = STOP_NODE;
        bus.left    = 1'b0;
        bus.right   = 1'b0;
        bus.reverse = 1'b0;
        if (state_q == ST_RUN) begin
            bus.node    = rd_entry.node;
            bus.left    = turn[0];
            bus.right   = turn[1];
            bus.reverse = turn[2];
        end
        bus.step = step_q;
        bus.busy = (state_q == ST_RUN);
        bus.done = (state_q == ST_DONE);
`ifdef PATH_SEQUENCER_WATCHDOG_EN
        bus.fault = (state_q == ST_FAULT);
`else
        bus.fault = 1'b0;
`endif
    end

endmodule

// File: tb/tb_path_sequencer.sv
// Directed self-checking bench for path_sequencer; watchdog scenario runs
// when PATH_SEQUENCER_WATCHDOG_EN is defined.
module tb_path_sequencer;

    localparam int TB_TIMEOUT = 100;

    logic clk_50 = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #10 clk_50 = ~clk_50;

    path_sequencer_if bus ();

    path_sequencer #(
        .DEPTH     (16),
        .TIMEOUT   (TB_TIMEOUT),
        .STOP_NODE (6'd22)
    ) dut (
        .clk_50 (clk_50),
        .reset  (reset),
        .bus    (bus.slave)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [5:0] node, input logic [2:0] turn_rrl,
                             input logic [3:0] step, input logic busy, input logic done);
        check_eq({tag, ".node"},    32'(bus.node), 32'(node));
        check_eq({tag, ".turn"},    32'({bus.reverse, bus.right, bus.left}), 32'(turn_rrl));
        check_eq({tag, ".step"},    32'(bus.step), 32'(step));
        check_eq({tag, ".busy"},    32'(bus.busy), 32'(busy));
        check_eq({tag, ".done"},    32'(bus.done), 32'(done));
    endtask

    task automatic write_entry(input logic [3:0] addr, input logic [7:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic start_path(input logic [4:0] len);
        bus.path_len = len;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
    endtask

    task automatic pulse_event();
        bus.node_event = 1'b1;
        tick();
        tick();
        bus.node_event = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        bus.wr_en      = 1'b0;
        bus.wr_addr    = 4'd0;
        bus.wr_data    = 8'd0;
        bus.path_len   = 5'd0;
        bus.start      = 1'b0;
        bus.node_event = 1'b0;
        reset          = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_out("reset", 6'd22, 3'b000, 4'd0, 1'b0, 1'b0);
        check_eq("reset.fault", 32'(bus.fault), 32'd0);

        // Load {left 1, right 5, straight 9} and run the full path.
        write_entry(4'd0, 8'h41);
        write_entry(4'd1, 8'h85);
        write_entry(4'd2, 8'h09);
        start_path(5'd3);
        check_out("start", 6'd1, 3'b001, 4'd0, 1'b1, 1'b0);
        pulse_event();
        check_out("ev1", 6'd5, 3'b010, 4'd1, 1'b1, 1'b0);
        pulse_event();
        check_out("ev2", 6'd9, 3'b000, 4'd2, 1'b1, 1'b0);
        pulse_event();
        check_out("ev3_done", 6'd22, 3'b000, 4'd2, 1'b0, 1'b1);

        // Restart from DONE; writes and start during RUN must be ignored.
        start_path(5'd3);
        check_out("restart", 6'd1, 3'b001, 4'd0, 1'b1, 1'b0);
        write_entry(4'd0, 8'hFF);
        check_out("wr_in_run", 6'd1, 3'b001, 4'd0, 1'b1, 1'b0);
        start_path(5'd2);
        check_out("start_in_run", 6'd1, 3'b001, 4'd0, 1'b1, 1'b0);

        // Held level must advance exactly once.
        bus.node_event = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        check_out("held_evt", 6'd5, 3'b010, 4'd1, 1'b1, 1'b0);

        // Reset at step 1 aborts; memory survives for a replay.
        do_reset();
        bus.node_event = 1'b0;
        check_out("abort", 6'd22, 3'b000, 4'd0, 1'b0, 1'b0);
        start_path(5'd3);
        check_out("replay", 6'd1, 3'b001, 4'd0, 1'b1, 1'b0);
        do_reset();

        // Out-of-range lengths and idle events have no effect.
        start_path(5'd0);
        check_out("len0", 6'd22, 3'b000, 4'd0, 1'b0, 1'b0);
        start_path(5'd17);
        check_out("len17", 6'd22, 3'b000, 4'd0, 1'b0, 1'b0);
        pulse_event();
        check_out("idle_evt", 6'd22, 3'b000, 4'd0, 1'b0, 1'b0);

        // Reset wins over a simultaneous start.
        reset        = 1'b1;
        bus.path_len = 5'd3;
        bus.start    = 1'b1;
        tick();
        reset     = 1'b0;
        bus.start = 1'b0;
        check_out("rst_vs_start", 6'd22, 3'b000, 4'd0, 1'b0, 1'b0);

        // Write in the same cycle as an accepted start is dropped.
        bus.wr_en    = 1'b1;
        bus.wr_addr  = 4'd0;
        bus.wr_data  = 8'hC3;
        bus.path_len = 5'd1;
        bus.start    = 1'b1;
        tick();
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        check_out("wr_with_start", 6'd1, 3'b001, 4'd0, 1'b1, 1'b0);
        pulse_event();
        check_out("len1_done", 6'd22, 3'b000, 4'd0, 1'b0, 1'b1);

        // Writes allowed in DONE; reverse move code.
        write_entry(4'd0, 8'hC3);
        start_path(5'd1);
        check_out("reverse", 6'd3, 3'b100, 4'd0, 1'b1, 1'b0);
        do_reset();

`ifdef PATH_SEQUENCER_WATCHDOG_EN
        start_path(5'd3);
        for (int i = 0; i < TB_TIMEOUT - 1; i++) tick();
        check_eq("wd_before.fault", 32'(bus.fault), 32'd0);
        check_eq("wd_before.busy", 32'(bus.busy), 32'd1);
        tick();
        check_eq("wd_at.fault", 32'(bus.fault), 32'd1);
        check_out("wd_at", 6'd22, 3'b000, 4'd0, 1'b0, 1'b0);
        start_path(5'd3);
        check_eq("wd_start_ign.fault", 32'(bus.fault), 32'd1);
        check_eq("wd_start_ign.busy", 32'(bus.busy), 32'd0);
        do_reset();
        check_eq("wd_reset.fault", 32'(bus.fault), 32'd0);
        check_out("wd_reset", 6'd22, 3'b000, 4'd0, 1'b0, 1'b0);
`else
        start_path(5'd3);
        for (int i = 0; i < 3 * TB_TIMEOUT; i++) tick();
        check_eq("nowd.fault", 32'(bus.fault), 32'd0);
        check_out("nowd", 6'd3, 3'b100, 4'd0, 1'b1, 1'b0);
        do_reset();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/path_sequencer.md
PATH_SEQUENCER -- requirements
Module: path_sequencer

Interface
REQ-001 Parameter DEPTH, 16, number of path entries (address width 4).
REQ-002 Parameter TIMEOUT, 50_000_000, watchdog limit in clk_50 cycles (1 s).
REQ-003 Parameter STOP_NODE, 22, node code driven when the path is finished or faulted.
REQ-004 clk_50  in  1  sole clock, all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 wr_en  in  1  path-memory write strobe.
REQ-007 wr_addr  in  4  entry address.
REQ-008 wr_data  in  8  [5:0] node number, [7:6] move code: 00 straight, 01 left, 10 right, 11 reverse.
REQ-009 path_len  in  5  number of valid entries, sampled on start.
REQ-010 start  in  1  single-cycle start request.
REQ-011 node_event  in  1  node-arrival level from the line-follower (r_node_detected).
REQ-012 node  out  6  current target node to the line-follower.
REQ-013 left, right, reverse  out  1 each  turn command for the current node.
REQ-014 step  out  4  index of the current entry.
REQ-015 busy, done, fault  out  1 each  status flags.

Function
REQ-016 States: IDLE, RUN, DONE, FAULT; one-hot status: busy=RUN, done=DONE, fault=FAULT.
REQ-017 Memory write occurs on wr_en only in IDLE, DONE or FAULT; writes in RUN are ignored.
REQ-018 start is accepted in IDLE or DONE only when 1 <= path_len <= 16; otherwise it is ignored with no state change.
REQ-019 wr_en in the same cycle as an accepted start is ignored.
REQ-020 Accepted start: next cycle state=RUN, step=0, node/turn outputs show entry 0 (1-cycle latency).
REQ-021 node_event is registered once and edge-detected; only a 0->1 transition counts as an event.
REQ-022 Event in RUN with step < len-1: step increments, outputs show new entry on the next cycle.
REQ-023 Event in RUN with step = len-1: state=DONE, node=STOP_NODE, turn outputs 0, step holds.
REQ-024 At most one of left/right/reverse is high; move code 00 drives all three low.
REQ-025 start in RUN is ignored; events outside RUN are ignored.
REQ-026 Outside RUN, node=STOP_NODE and turn outputs are 0.

Reset
REQ-027 reset: state=IDLE, step=0, node=STOP_NODE, left=right=reverse=0, busy=done=fault=0, watchdog=0, edge register=0.
REQ-028 reset mid-RUN aborts the path in one cycle; memory contents are not cleared.
REQ-029 reset overrides start, wr_en and node_event in the same cycle.

Configuration
REQ-030 Macro PATH_SEQUENCER_WATCHDOG_EN compiles in a 32-bit watchdog counter.
REQ-031 With it defined: counter clears on entry to RUN and on every event, increments each RUN cycle; when it reaches TIMEOUT-1 state goes to FAULT.
REQ-032 FAULT is exited only by reset; start is ignored in FAULT.
REQ-033 If the timeout and an event coincide, the event wins.
REQ-034 Without it: no counter, FAULT unreachable, fault tied 0.

Structure
REQ-035 Shared package sm_path_pkg holds the move-code constants, the state encoding, STOP_NODE and the entry record type (node + move).
REQ-036 One sub-module, path_mem: DEPTH x 8 register file, synchronous write, asynchronous read.

Verification
REQ-037 Load {0x41 (left, 1), 0x85 (right, 5), 0x09 (straight, 9)}, path_len=3, start -> next cycle node=1, left=1, busy=1.
REQ-038 Three node_event pulses -> node 5/right, then 9/straight, then node=22, done=1, busy=0.
REQ-039 path_len=0 or 17 with start -> state stays IDLE, node=22.
REQ-040 node_event held high 100 cycles -> step advances once only.
REQ-041 With PATH_SEQUENCER_WATCHDOG_EN, TIMEOUT=100, no events after start -> fault=1 at cycle 100, node=22, start ignored until reset.
REQ-042 reset asserted at step 1 of a 3-entry path -> IDLE next cycle; restart without reload -> entry 0 replayed unchanged.
